// File: rtl/wb_spi_multi_if.sv
// wb_spi_multi_if: Wishbone classic slave bus bundle for the SPI master
interface wb_spi_multi_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic        wb_ack_o;
    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );
    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_spi_multi.sv
// wb_spi_multi: Wishbone-controlled SPI master with software chip selects and all four modes
module wb_spi_multi #(
    parameter int NUM_CS  = 3,
    parameter int DATA_W  = 32,
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 49
) (
    input  logic              clk,
    input  logic              reset,
    wb_spi_multi_if.slave     wb,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] cs_n,
    output logic              intr
);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;
    state_e            state_q, state_d;
    logic [8:0]        ctrl_q, ctrl_d;
    logic [DIV_W-1:0]  div_q, div_d, dvs_q, dvs_d, dv_q, dv_d;
    logic [NUM_CS-1:0] cs_q, cs_d;
    logic [DATA_W-1:0] rx_q, rx_d, sh_q, sh_d, rs_q, rs_d;
    logic [4:0]        cnt_q, cnt_d, len_q, len_d, len_eff;
    logic              sck_q, sck_d, cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic              done_q, done_d, ovr_q, ovr_d, ack_q, ack_d;
    logic [31:0]       dat_q, dat_d, rdata;
    logic              acc, wr, rd, tx_wr, tick, lead, samp;
    logic [2:0]        sel;
    logic              unused_ok;

    assign unused_ok = ^{wb.wb_sel_i, wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

    always_comb begin
        acc     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
        wr      = acc & wb.wb_we_i;
        rd      = acc & ~wb.wb_we_i;
        sel     = wb.wb_adr_i[4:2];
        tx_wr   = wr && sel == 3'd3;
        len_eff = (32'(ctrl_q[7:3]) >= 32'(DATA_W)) ? 5'(DATA_W - 1) : ctrl_q[7:3];
        rdata   = sel == 3'd0 ? 32'(ctrl_q) :
                  sel == 3'd1 ? 32'(div_q) :
                  sel == 3'd2 ? 32'(cs_q) :
                  sel == 3'd4 ? 32'(rx_q) :
                  sel == 3'd5 ? {29'd0, ovr_q, done_q, state_q != IDLE} : 32'd0;
        tick    = dv_q == dvs_q;
        lead    = sck_q == cpol_q;
        samp    = lead ^ cpha_q;
        ack_d   = acc;
        dat_d   = rd ? rdata : 32'd0;
        ctrl_d  = (wr && sel == 3'd0) ? wb.wb_dat_i[8:0] : ctrl_q;
        div_d   = (wr && sel == 3'd1) ? wb.wb_dat_i[DIV_W-1:0] : div_q;
        cs_d    = (wr && sel == 3'd2) ? wb.wb_dat_i[NUM_CS-1:0] : cs_q;
        done_d  = ((wr && sel == 3'd5 && wb.wb_dat_i[1]) || (rd && sel == 3'd4)) ? 1'b0 : done_q;
        ovr_d   = (wr && sel == 3'd5 && wb.wb_dat_i[2]) ? 1'b0 :
                  (tx_wr && state_q != IDLE) ? 1'b1 : ovr_q;
        state_d = state_q;
        rx_d    = rx_q;
        sh_d    = sh_q;
        rs_d    = rs_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        dv_d    = dv_q;
        dvs_d   = dvs_q;
        sck_d   = sck_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        unique case (state_q)
            IDLE: if (tx_wr) begin
                sh_d    = wb.wb_dat_i[DATA_W-1:0];
                rs_d    = '0;
                cnt_d   = len_eff;
                len_d   = len_eff;
                dv_d    = '0;
                dvs_d   = div_q;
                sck_d   = ctrl_q[1];
                cpol_d  = ctrl_q[1];
                cpha_d  = ctrl_q[0];
                lsb_d   = ctrl_q[2];
                state_d = SHIFT;
            end
            SHIFT: if (tick) begin
                dv_d  = '0;
                sck_d = ~sck_q;
                if (samp)
                    rs_d = lsb_q ? ((rs_q >> 1) | (DATA_W'(spi_miso) << len_q))
                                 : {rs_q[DATA_W-2:0], spi_miso};
                // CPHA=1 presents the first bit from load, so its first leading edge must not advance
                if (!samp && !(cpha_q && cnt_q == len_q))
                    sh_d = lsb_q ? sh_q >> 1 : sh_q << 1;
                if (!lead && cnt_q == 5'd0)
                    state_d = FINISH;
                else if (!lead)
                    cnt_d = cnt_q - 1'b1;
            end else begin
                dv_d = dv_q + 1'b1;
            end
            FINISH: begin
                rx_d    = rs_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            div_q   <= DIV_W'(DIV_RST);
            cs_q    <= '0;
            rx_q    <= '0;
            sh_q    <= '0;
            rs_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            dv_q    <= '0;
            dvs_q   <= '0;
            sck_q   <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            cs_q    <= cs_d;
            rx_q    <= rx_d;
            sh_q    <= sh_d;
            rs_q    <= rs_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            dv_q    <= dv_d;
            dvs_q   <= dvs_d;
            sck_q   <= sck_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign spi_sck     = state_q == SHIFT ? sck_q : ctrl_q[1];
    assign spi_mosi    = state_q == SHIFT ? (lsb_q ? sh_q[0] : sh_q[len_q]) : 1'b0;
    assign cs_n        = ~cs_q;
    assign intr        = done_q & ctrl_q[8];
endmodule
